sync_fifo_rd_port: RTL and testbench
====================================

// Module: sync_fifo_rd_port
// PURPOSE
//   Read-side controller for the synchronous FIFO memory. Owns the read pointer,
//   drives the memory's combinational read address, and prefetches the head entry
//   into a registered output stage presented as a valid/ready stream. Returns its
//   extended read pointer to the write-side controller for full detection.
//   Sits between sync_fifo_mem (rd_addr/rd_data) and the downstream consumer.
// PARAMETERS
//   MEM_DEPTH   `FIFO_DEPTH         memory entries; power of two, >= 2
//   DATA_WIDTH  `DATA_WIDTH         width of one entry
//   ADDR_WIDTH  $clog2(MEM_DEPTH)   memory address width
// PORTS
//   clk          in   1              clock, all state updates on rising edge
//   reset_n      in   1              synchronous reset, active low
//   wr_ptr       in   ADDR_WIDTH+1   write-side pointer (MSB = wrap bit), registered
//   mem_rd_data  in   DATA_WIDTH     memory read data for rd_addr (combinational)
//   rd_addr      out  ADDR_WIDTH     memory read address = rd_ptr[ADDR_WIDTH-1:0]
//   rd_ptr       out  ADDR_WIDTH+1   read pointer (MSB = wrap bit), to write side
//   flush        in   1              synchronous discard of all buffered data
//   m_data       out  DATA_WIDTH     output data, registered
//   m_valid      out  1              m_data holds a valid entry
//   m_ready      in   1              consumer accepts m_data this cycle
//   empty        out  1              no entry in memory and none in output stage
//   count        out  ADDR_WIDTH+2   entries held: (wr_ptr - rd_ptr) + m_valid
// BEHAVIOUR
//   Reset (reset_n=0 at edge): rd_ptr=0, m_valid=0, m_data=0; hence rd_addr=0,
//     empty=1, count=0. Reset has priority over flush and all other inputs.
//   mem_empty = (wr_ptr == rd_ptr); mem_level = wr_ptr - rd_ptr, modulo 2^(ADDR_WIDTH+1).
//   Output stage is a 2-state FSM encoded by m_valid: IDLE (0) / HOLD (1).
//   load = (!m_valid || m_ready) && !mem_empty.
//   On load: m_data <= mem_rd_data; rd_ptr <= rd_ptr + 1; m_valid <= 1.
//   Else if m_valid && m_ready: m_valid <= 0; m_data holds its last value.
//   Else: no change. m_data never changes while m_valid=1 && m_ready=0.
//   Throughput: one entry per cycle when m_ready=1 and memory non-empty
//     (pop and refill in the same edge).
//   Latency: wr_ptr advancing at edge N (memory non-empty, stage IDLE) ->
//     m_valid=1 with that entry after edge N+1.
//   Pointer wrap: rd_ptr increments modulo 2^(ADDR_WIDTH+1); rd_addr wraps
//     MEM_DEPTH-1 -> 0 with the wrap bit toggling.
//   Full (mem_level == MEM_DEPTH) is detected by the write side; this block
//     needs no special case. count maximum = MEM_DEPTH+1.
//   flush=1 at edge (reset_n=1): rd_ptr <= wr_ptr, m_valid <= 0; m_ready and
//     load ignored that cycle. Entries written in the same edge (wr_ptr changes
//     next cycle) are retained.
//   empty and count are combinational from registered state and wr_ptr.
//   Never reads when mem_empty; never drops or duplicates an entry.
// TESTING (MEM_DEPTH=8, DATA_WIDTH=8)
//   Reset: hold reset_n=0 with wr_ptr=4 -> rd_ptr=0, m_valid=0, m_data=0 after
//     edge; release -> entry 0 loaded next edge, count=4.
//   Stream: write 0x10..0x17, m_ready=1 -> m_data 0x10..0x17 on 8 consecutive
//     cycles, then m_valid=0, empty=1, rd_ptr=8 (wrap bit set, rd_addr=0).
//   Backpressure: 3 entries, m_ready=0 -> m_valid=1, m_data=first entry stable,
//     rd_ptr advanced by 1 only, count=3; m_ready=1 -> next two in order.
//   Full + wrap: rd_ptr=6, fill 8 entries (wr_ptr=14), m_ready=0 -> count=8
//     after load; drain -> addresses 6,7,0..5 read in order, rd_ptr=14.
//   Flush: 5 entries buffered, m_valid=1, flush=1 for one cycle -> m_valid=0,
//     rd_ptr=wr_ptr, empty=1, count=0 next cycle.
//   Flush + reset together: reset_n=0, flush=1 -> reset values (rd_ptr=0).

Source files
------------

// File: rtl/sync_fifo_rd_port.sv
// Read-side controller of the synchronous FIFO: owns the read pointer and prefetches
// the head entry into a registered valid/ready output stage.
module sync_fifo_rd_port #(
    parameter int MEM_DEPTH  = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH:0]   wr_ptr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH:0]   rd_ptr,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  empty,
    output logic [ADDR_WIDTH+1:0] count
);

    localparam logic [0:0]          ST_IDLE = 1'b0;
    localparam logic [0:0]          ST_HOLD = 1'b1;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [0:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;

    logic                  mem_empty;
    logic [ADDR_WIDTH:0]   mem_level;
    logic                  load;

    // Pointer difference is taken modulo 2^(ADDR_WIDTH+1), so a full memory reads as MEM_DEPTH.
    assign mem_empty = (wr_ptr == rd_ptr_q);
    assign mem_level = wr_ptr - rd_ptr_q;
    assign load      = ((state_q == ST_IDLE) || m_ready) && !mem_empty;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        state_d  = state_q;
        m_data_d = m_data_q;
        if (flush) begin
            rd_ptr_d = wr_ptr;
            state_d  = ST_IDLE;
        end else if (load) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            state_d  = ST_HOLD;
            m_data_d = mem_rd_data;
        end else if ((state_q == ST_HOLD) && m_ready) begin
            state_d  = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            state_q  <= ST_IDLE;
            m_data_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            state_q  <= state_d;
            m_data_q <= m_data_d;
        end
    end

    assign rd_ptr  = rd_ptr_q;
    assign rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];
    assign m_data  = m_data_q;
    assign m_valid = (state_q == ST_HOLD);
    assign empty   = mem_empty && (state_q == ST_IDLE);
    assign count   = {1'b0, mem_level} + {{(ADDR_WIDTH+1){1'b0}}, state_q};

endmodule

// File: tb/tb_sync_fifo_rd_port.sv
// Bench for sync_fifo_rd_port: a bench-side memory and write pointer feed the DUT,
// and a queue-based model of the buffered entries predicts every output.
module tb_sync_fifo_rd_port;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] wr_ptr;
    logic [7:0] mem_rd_data;
    logic [2:0] rd_addr;
    logic [3:0] rd_ptr;
    logic       flush;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       empty;
    logic [4:0] count;

    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_load;
    logic [3:0] wr_load_val;
    logic [7:0] mem [8];

    int vectors     = 0;
    int miscompares = 0;

    // Model: entries still in memory, the output stage, and the expected read pointer.
    logic [7:0] mq [$];
    logic       msv;
    logic [7:0] msd;
    logic [3:0] mrd;
    bit         started = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_rd_port #(.MEM_DEPTH(8), .DATA_WIDTH(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_ptr     (wr_ptr),
        .mem_rd_data(mem_rd_data),
        .rd_addr    (rd_addr),
        .rd_ptr     (rd_ptr),
        .flush      (flush),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .empty      (empty),
        .count      (count)
    );

    assign mem_rd_data = mem[rd_addr];

    initial begin
        wr_ptr = '0;
        for (int i = 0; i < 8; i++) mem[i] = 8'hEE;
    end

    always @(posedge clk) begin
        if (wr_load) wr_ptr <= wr_load_val;
        else if (wr_en) wr_ptr <= wr_ptr + 4'd1;
        if (wr_en) mem[wr_ptr[2:0]] <= wr_data;
    end

    always @(posedge clk) begin
        if (!reset_n) begin
            int tgt;
            int slot;
            mq.delete();
            msv = 1'b0;
            msd = 8'h00;
            mrd = 4'd0;
            tgt = wr_load ? int'(wr_load_val) : int'(wr_ptr) + int'(wr_en);
            for (int i = 0; i < tgt; i++) begin
                slot = i % 8;
                mq.push_back((wr_en && slot == int'(wr_ptr[2:0])) ? wr_data : mem[slot]);
            end
            started = 1'b1;
        end else if (flush) begin
            mq.delete();
            msv = 1'b0;
            mrd = wr_ptr;
            if (wr_en) mq.push_back(wr_data);
        end else begin
            if ((!msv || m_ready) && mq.size() > 0) begin
                msd = mq.pop_front();
                msv = 1'b1;
                mrd = mrd + 4'd1;
            end else if (msv && m_ready) begin
                msv = 1'b0;
            end
            if (wr_en) mq.push_back(wr_data);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("model_m_valid", 32'(m_valid), 32'(msv));
            chk("model_m_data", 32'(m_data), 32'(msd));
            chk("model_rd_ptr", 32'(rd_ptr), 32'(mrd));
            chk("model_rd_addr", 32'(rd_addr), 32'(mrd[2:0]));
            chk("model_count", 32'(count), 32'(mq.size() + int'(msv)));
            chk("model_empty", 32'(empty), 32'((mq.size() == 0) && !msv));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; m_ready = 1'b0;
        wr_en = 1'b0; wr_data = 8'h00; wr_load = 1'b0; wr_load_val = 4'd0;
        #1;
        tick();

        // Reset held while four entries are written.
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'hA0 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        tick();
        chk("rst_rd_ptr", 32'(rd_ptr), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_count", 32'(count), 32'd4);
        reset_n = 1'b1;
        tick();
        chk("rel_m_valid", 32'(m_valid), 32'd1);
        chk("rel_m_data", 32'(m_data), 32'hA0);
        chk("rel_count", 32'(count), 32'd4);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("drain0_empty", 32'(empty), 32'd1);

        // Flush and reset together while the stage holds data.
        m_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wr_en = 1'b1; wr_data = 8'h20 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        chk("pre_rstfl_m_valid", 32'(m_valid), 32'd1);
        reset_n = 1'b0; flush = 1'b1; wr_load = 1'b1; wr_load_val = 4'd0;
        tick();
        chk("rstfl_rd_ptr", 32'(rd_ptr), 32'd0);
        chk("rstfl_m_valid", 32'(m_valid), 32'd0);
        chk("rstfl_m_data", 32'(m_data), 32'd0);
        chk("rstfl_empty", 32'(empty), 32'd1);
        reset_n = 1'b1; flush = 1'b0; wr_load = 1'b0;

        // Streaming at full rate.
        m_ready = 1'b1;
        for (int t = 0; t < 10; t++) begin
            wr_en = (t < 8); wr_data = 8'h10 + 8'(t);
            tick();
            if (t >= 1 && t <= 8) begin
                chk("stream_valid", 32'(m_valid), 32'd1);
                chk("stream_data", 32'(m_data), 32'h10 + 32'(t - 1));
            end
        end
        wr_en = 1'b0;
        chk("stream_end_valid", 32'(m_valid), 32'd0);
        chk("stream_end_empty", 32'(empty), 32'd1);
        chk("stream_end_rd_ptr", 32'(rd_ptr), 32'd8);
        chk("stream_end_rd_addr", 32'(rd_addr), 32'd0);

        // Backpressure.
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_en = (i < 3); wr_data = 8'h30 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 32'(m_valid), 32'd1);
            chk("bp_data", 32'(m_data), 32'h30);
            chk("bp_rd_ptr", 32'(rd_ptr), 32'd9);
            chk("bp_count", 32'(count), 32'd3);
            tick();
        end
        m_ready = 1'b1;
        tick();
        chk("bp_next1", 32'(m_data), 32'h31);
        tick();
        chk("bp_next2", 32'(m_data), 32'h32);
        tick();
        chk("bp_done_valid", 32'(m_valid), 32'd0);

        // Position read pointer at 6, then fill and drain across the wrap.
        m_ready = 1'b0;
        reset_n = 1'b0; wr_load = 1'b1; wr_load_val = 4'd6;
        tick();
        reset_n = 1'b1; wr_load = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("wrap_start_rd_ptr", 32'(rd_ptr), 32'd6);
        chk("wrap_start_rd_addr", 32'(rd_addr), 32'd6);
        chk("wrap_start_empty", 32'(empty), 32'd1);
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'h50 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        chk("full_count", 32'(count), 32'd8);
        chk("full_m_data", 32'(m_data), 32'h50);
        m_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            chk("wrap_rd_addr", 32'(rd_addr), 32'((7 + k) % 8));
            tick();
            chk("wrap_data", 32'(m_data), 32'h51 + 32'(k));
        end
        tick();
        chk("wrap_end_rd_ptr", 32'(rd_ptr), 32'd14);
        chk("wrap_end_empty", 32'(empty), 32'd1);

        // Flush with buffered data, then flush with a same-edge write.
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'h60 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        chk("preflush_valid", 32'(m_valid), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", 32'(m_valid), 32'd0);
        chk("flush_rd_ptr", 32'(rd_ptr), 32'(wr_ptr));
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_count", 32'(count), 32'd0);
        flush = 1'b1; wr_en = 1'b1; wr_data = 8'h70;
        tick();
        flush = 1'b0; wr_en = 1'b0;
        chk("flushwr_count", 32'(count), 32'd1);
        tick();
        chk("flushwr_valid", 32'(m_valid), 32'd1);
        chk("flushwr_data", 32'(m_data), 32'h70);
        m_ready = 1'b1;
        tick();
        chk("final_empty", 32'(empty), 32'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
